lcd_spi_tx: RTL
===============

Name: lcd_spi_tx

Overview:
- Parametrised SPI write engine for ST7735-class LCD controllers. Serialises one command/data word per valid/ready handshake, with a programmable sclk divider, SPI mode (CPOL/CPHA), bit order and word length (8 or DATA_W bits).
- Supports burst framing: CS stays low across consecutive words until a word tagged last is sent or an explicit release arrives.
- Sits between the LCD init/pixel sequencers and the panel pins.

Parameters:
- DATA_W, 16, maximum word length in bits; legal 8..32.
- DIV, 3, sclk half-period in sys_clk cycles; legal >=1.
- CPOL, 0, sclk idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- LSB_FIRST, 0, 1 = shift out bit 0 first.
- CS_GAP, 2, minimum number of sys_clk cycles CS stays high after a frame ends.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_W  word to send; only [7:0] is used when tx_wide=0.
- tx_dc  in  1  D/C level for this word (0 = command, 1 = data).
- tx_wide  in  1  1 = send DATA_W bits, 0 = send 8 bits.
- tx_last  in  1  1 = release CS after this word.
- tx_valid  in  1  word offered.
- tx_ready  out  1  engine can accept a word.
- cs_release  in  1  pulse; ends an open burst without sending a word.
- busy  out  1  high in every state except IDLE.
- wr_done  out  1  one-cycle pulse at the end of each word.
- cs  out  1  chip select, active low.
- dc  out  1  D/C pin.
- sclk  out  1  SPI clock.
- mosi  out  1  SPI data.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous, active-low, on sys_rst_n.
- Reset values: cs=1, sclk=CPOL, mosi=0, dc=0, wr_done=0, busy=0, tx_ready=1, state=IDLE. Reset asserted mid-frame forces these values immediately and discards the word.
- States: IDLE, SETUP, SHIFT, HOLD, BURST, GAP.
- tx_ready=1 only in IDLE and BURST. A word is accepted on a cycle where tx_valid && tx_ready. On acceptance the engine latches tx_data, tx_wide and tx_last, and registers dc from tx_dc. dc then holds until the next acceptance.
- Word length n = tx_wide ? DATA_W : 8.
- Bit order: LSB_FIRST=0 sends bit n-1 first; LSB_FIRST=1 sends bit 0 first.
- Timing, with acceptance at cycle T:
  - cs=0 from T+1.
  - SETUP lasts DIV cycles.
  - sclk toggles at T+1+k*DIV for k=1..2n. Odd k is the leading edge; even k is the trailing edge.
  - After edge 2n, HOLD lasts DIV cycles with sclk=CPOL.
  - wr_done pulses at cycle T+1+(2n+1)*DIV, on HOLD exit.
- mosi, CPHA=0: the first bit is valid from T+1. Each following bit is driven on trailing edges k=2,4,..,2n-2. mosi holds after the last bit.
- mosi, CPHA=1: bit i is driven at leading edge k=2i+1. mosi is unchanged during SETUP.
- HOLD exit:
  - If latched tx_last=1, go to GAP: cs=1 on the wr_done cycle, then CS_GAP cycles with tx_ready=0, then IDLE.
  - If latched tx_last=0, go to BURST: cs stays 0, sclk=CPOL, tx_ready=1.
- BURST:
  - Acceptance goes to SETUP with no cs glitch; the next word's first sclk edge comes DIV cycles after acceptance+1.
  - cs_release (without a valid word) goes to GAP.
  - tx_valid and cs_release in the same cycle: the word is accepted and cs_release is ignored.
  - The engine waits in BURST indefinitely.
- cs_release outside BURST is ignored. tx_valid is ignored while tx_ready=0; no word is lost, because the producer must hold it.
- tx_data, tx_wide and tx_last may change freely after acceptance.
- The half-period counter runs only outside IDLE/BURST and clears on each state entry. No free-running counter.
- A word with tx_wide=1 when DATA_W=8 behaves exactly like tx_wide=0.

Test Plan:
- DIV=3, CPOL=0, CPHA=0, MSB first; send 0x1A5 with tx_dc=1, tx_wide=0, tx_last=1, accepted at T -> cs low T+1..T+51, dc=1, mosi sequence 1,0,1,0,0,1,0,1, sclk rises at T+4, T+10, ..., T+46, wr_done at T+52, cs high T+52..T+53, tx_ready back at T+54.
- Burst: command 0x2C (last=0), then 16-bit pixel 0xF800 (wide, last=1) offered immediately -> cs stays low between the two words, dc goes 0 then 1 at the second acceptance, 24 rising edges total, two wr_done pulses, one cs rise.
- CPOL=1, CPHA=1, LSB_FIRST=1, send 0x01 -> sclk idles 1; mosi changes only on falling (leading) edges; bit0=1 sampled on the first rising edge; all remaining bits 0.
- Open burst, then cs_release pulse with no valid -> cs high the next cycle, tx_ready low for CS_GAP cycles; a simultaneous valid+cs_release instead starts a new word with cs kept low.
- Assert sys_rst_n low at edge 7 of a frame -> cs=1, sclk=CPOL, mosi=0, busy=0, tx_ready=1 immediately; after release, a new word transmits correctly from SETUP.
- DIV=1, tx_valid held high with last=1 -> back-to-back frames separated by exactly CS_GAP+1 cs-high cycles; no handshake is dropped or duplicated.

Source files
------------

// File: rtl/lcd_spi_tx_if.sv
// rtl/lcd_spi_tx_if.sv - word handshake bundle between LCD sequencers and lcd_spi_tx
//
// Purpose: carries one command/data word per valid/ready handshake plus the
// burst release pulse.
// Signals:
//   tx_data    word to send (only [7:0] used when tx_wide=0)
//   tx_dc      D/C level for this word (0 = command, 1 = data)
//   tx_wide    1 = DATA_W-bit word, 0 = 8-bit word
//   tx_last    1 = release CS after this word
//   tx_valid   word offered by the producer
//   tx_ready   engine can accept a word
//   cs_release pulse that closes an open burst without a word
// Modports: master = producer (sequencer), slave = engine.

interface lcd_spi_tx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_dc;
  logic              tx_wide;
  logic              tx_last;
  logic              tx_valid;
  logic              tx_ready;
  logic              cs_release;

  modport master (
    output tx_data, tx_dc, tx_wide, tx_last, tx_valid, cs_release,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_dc, tx_wide, tx_last, tx_valid, cs_release,
    output tx_ready
  );
endinterface

// File: rtl/lcd_spi_tx.sv
// rtl/lcd_spi_tx.sv - SPI write engine for ST7735-class LCD controllers
//
// Purpose: serialises one 8- or DATA_W-bit word per handshake onto cs/dc/sclk/mosi
// with a programmable half-period, SPI mode and bit order. CS stays low across
// a burst until a word tagged last is sent or cs_release closes the burst.
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   tx                  word handshake (lcd_spi_tx_if slave modport)
//   busy                high in every state except IDLE
//   wr_done             one-cycle pulse at the end of each word
//   cs, dc, sclk, mosi  panel pins (cs active low)

module lcd_spi_tx #(
  parameter int   DATA_W    = 16,
  parameter int   DIV       = 3,
  parameter logic CPOL      = 1'b0,
  parameter logic CPHA      = 1'b0,
  parameter logic LSB_FIRST = 1'b0,
  parameter int   CS_GAP    = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  lcd_spi_tx_if.slave tx,
  output logic        busy,
  output logic        wr_done,
  output logic        cs,
  output logic        dc,
  output logic        sclk,
  output logic        mosi
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_BURST = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam int CMAX = (DIV > CS_GAP) ? DIV : CS_GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int EW   = $clog2(2 * DATA_W + 1);

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((CS_GAP > 0) ? CS_GAP - 1 : 0);

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [EW-1:0]     ecnt;
  logic [DATA_W-1:0] sh;
  logic              lat_wide;
  logic              lat_last;

  logic              accept;
  logic              div_tick;
  logic [EW-1:0]     edge_k;
  logic [EW-1:0]     edge_last;
  logic [DATA_W-1:0] data_lo;
  logic [DATA_W-1:0] sh_init;
  logic [DATA_W-1:0] init_rest;
  logic [DATA_W-1:0] sh_rest;
  logic              init_bit;
  logic              sh_bit;

  assign tx.tx_ready = (state == S_IDLE) || (state == S_BURST);
  assign busy        = (state != S_IDLE);
  assign accept      = tx.tx_valid && tx.tx_ready;
  assign div_tick    = (cnt == DIV_LAST);
  assign edge_k      = ecnt + EW'(1);
  assign edge_last   = lat_wide ? EW'(2 * DATA_W) : EW'(16);
  assign data_lo     = DATA_W'(tx.tx_data[7:0]);

  // The shift register is normalised so the next bit to send always sits at
  // one fixed end: bit 0 for LSB-first, bit DATA_W-1 for MSB-first. Narrow
  // MSB-first words are therefore left-justified.
  always_comb begin
    if (tx.tx_wide)     sh_init = tx.tx_data;
    else if (LSB_FIRST) sh_init = data_lo;
    else                sh_init = data_lo << (DATA_W - 8);
  end

  assign init_bit  = LSB_FIRST ? sh_init[0] : sh_init[DATA_W-1];
  assign init_rest = LSB_FIRST ? (sh_init >> 1) : (sh_init << 1);
  assign sh_bit    = LSB_FIRST ? sh[0] : sh[DATA_W-1];
  assign sh_rest   = LSB_FIRST ? (sh >> 1) : (sh << 1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ecnt     <= '0;
      sh       <= '0;
      lat_wide <= 1'b0;
      lat_last <= 1'b0;
      cs       <= 1'b1;
      dc       <= 1'b0;
      sclk     <= CPOL;
      mosi     <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      cnt     <= cnt + CW'(1);
      if (accept) begin
        // Acceptance from IDLE or BURST; cs simply stays low in a burst.
        state    <= S_SETUP;
        cnt      <= '0;
        ecnt     <= '0;
        cs       <= 1'b0;
        dc       <= tx.tx_dc;
        sclk     <= CPOL;
        lat_wide <= tx.tx_wide;
        lat_last <= tx.tx_last;
        if (!CPHA) begin
          // Mode 0/2: first bit must be on the wire before the leading edge.
          mosi <= init_bit;
          sh   <= init_rest;
        end else begin
          sh   <= sh_init;
        end
      end else begin
        case (state)
          S_IDLE: cnt <= '0;
          S_SETUP, S_SHIFT: begin
            if (div_tick) begin
              cnt  <= '0;
              sclk <= ~sclk;
              ecnt <= edge_k;
              // CPHA=1 drives on leading (odd) edges; CPHA=0 drives on trailing
              // (even) edges except the final one, after which mosi holds.
              if (CPHA ? edge_k[0] : (!edge_k[0] && (edge_k != edge_last))) begin
                mosi <= sh_bit;
                sh   <= sh_rest;
              end
              state <= (edge_k == edge_last) ? S_HOLD : S_SHIFT;
            end
          end
          S_HOLD: begin
            if (div_tick) begin
              cnt     <= '0;
              wr_done <= 1'b1;
              if (lat_last) begin
                cs    <= 1'b1;
                state <= (CS_GAP == 0) ? S_IDLE : S_GAP;
              end else begin
                state <= S_BURST;
              end
            end
          end
          S_BURST: begin
            cnt <= '0;
            if (tx.cs_release) begin
              cs    <= 1'b1;
              state <= S_GAP;
            end
          end
          S_GAP: begin
            if (cnt == GAP_LAST) begin
              cnt   <= '0;
              state <= S_IDLE;
            end
          end
          default: begin
            cnt   <= '0;
            cs    <= 1'b1;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
